// File: rtl/risc16_pkg.sv
// risc16_pkg: shared fetch-path widths, state encoding and buffer entry type.
package risc16_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/risc16_fetch_fifo.sv
// risc16_fetch_fifo: 2-entry buffer of fetched {pc, instr} pairs.
// Flush empties it; push into a full buffer is accepted only alongside a pop.
module risc16_fetch_fifo
    import risc16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/risc16_fetch_ctrl.sv
// risc16_fetch_ctrl: PC owner and fetch sequencer feeding decode.
// Define IFETCH_BOUND_EN to stop fetching past PC_LIMIT.
module risc16_fetch_ctrl
    import risc16_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_LIMIT = 16'h001C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

`ifdef IFETCH_BOUND_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [15:0]     r_fetch_count;

    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;
    logic [1:0]      w_count;
    logic            w_pop;
    logic            w_push;
    logic            w_slot;
    logic            w_oob;
    logic [PC_W-1:0] w_redir_pc;

    assign w_oob      = BOUND_EN && (r_fetch_pc > PC_LIMIT);
    assign w_pop      = inst_valid && inst_ready;
    assign w_slot     = (w_count != 2'd2) || w_pop;
    assign w_redir_pc = redirect_pc & ~PC_W'(1);
    assign w_push     = (r_state == S_FETCH) && !redirect_valid
                        && !halt_req && !w_oob && w_slot;
    assign w_entry    = '{pc: r_fetch_pc, instr: imem_rdata};

    risc16_fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Redirect keeps the current state; only halt_req can override it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_fetch_count <= 16'd0;
        end else begin
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(2);
            end
            if (halt_req) begin
                r_state <= S_HALT;
            end else if (!redirect_valid) begin
                case (r_state)
                    S_IDLE:  if (run) r_state <= S_FETCH;
                    S_FETCH: if (w_oob) r_state <= S_HALT;
                    S_HALT:  if (run) r_state <= S_FETCH;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = (w_count != 2'd0);
    assign inst_data   = w_head.instr;
    assign inst_pc     = w_head.pc;
    assign halted      = (r_state == S_HALT) && (w_count == 2'd0);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_risc16_fetch_ctrl.sv
// tb_risc16_fetch_ctrl: directed scenarios plus randomized run against
// a queue-based reference model of the fetch sequencer.
module tb_risc16_fetch_ctrl;

    localparam logic [15:0] LIMIT = 16'h001C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        inst_ready = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffer as queues, state 0=idle 1=fetch 2=halt.
    logic [15:0] mq_pc[$];
    logic [15:0] mq_in[$];
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    int          m_st;
    bit          m_bound;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return {a[7:0] ^ 8'hC3, 8'h5A + a[8:1]};
    endfunction

    assign imem_rdata = rom(imem_addr);

    always #5 clk = ~clk;

    risc16_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic model_step();
        bit pop;
        pop = (mq_pc.size() > 0) && inst_ready;
        if (pop) m_cnt = m_cnt + 16'd1;
        if (redirect_valid) begin
            mq_pc.delete();
            mq_in.delete();
            m_pc = redirect_pc & 16'hFFFE;
            if (halt_req) m_st = 2;
            return;
        end
        if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_in.pop_front());
        end
        if (halt_req) begin
            m_st = 2;
            return;
        end
        if (m_st != 1) begin
            if (run) m_st = 1;
        end else if (m_bound && m_pc > LIMIT) begin
            m_st = 2;
        end else if (mq_pc.size() < 2) begin
            mq_pc.push_back(m_pc);
            mq_in.push_back(rom(m_pc));
            m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_in.delete();
        m_pc  = 16'h0000;
        m_cnt = 16'd0;
        m_st  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        inst_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec += 6;
        if (imem_addr !== 16'h0000) begin
            n_err++; $display("FAIL reset.addr got=%h exp=0000", imem_addr);
        end
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL reset.valid got=%b exp=0", inst_valid);
        end
        if (inst_data !== 16'h0) begin
            n_err++; $display("FAIL reset.data got=%h exp=0000", inst_data);
        end
        if (inst_pc !== 16'h0) begin
            n_err++; $display("FAIL reset.pc got=%h exp=0000", inst_pc);
        end
        if (halted !== 1'b0) begin
            n_err++; $display("FAIL reset.halted got=%b exp=0", halted);
        end
        if (fetch_count !== 16'h0) begin
            n_err++; $display("FAIL reset.count got=%h exp=0000", fetch_count);
        end
        cycle();
        n_vec++;
        if (inst_valid !== 1'b0 || imem_addr !== 16'h0) begin
            n_err++;
            $display("FAIL idle.hold valid=%b addr=%h exp 0/0000",
                     inst_valid, imem_addr);
        end
    endtask

    task automatic test_startup();
        do_reset();
        run = 1'b1;
        inst_ready = 1'b1;
        cycle();
        n_vec++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL start.early_valid got=%b exp=0", inst_valid);
        end
        cycle();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 16'(2 * i)
                || inst_data !== rom(16'(2 * i))) begin
                n_err++;
                $display("FAIL start.seq%0d valid=%b pc=%h data=%h exp pc=%h",
                         i, inst_valid, inst_pc, inst_data, 16'(2 * i));
            end
            cycle();
        end
        n_vec++;
        if (fetch_count !== 16'd4) begin
            n_err++; $display("FAIL start.count got=%0d exp=4", fetch_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if (inst_pc !== 16'h0 || imem_addr !== 16'h4 || inst_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp.hold%0d pc=%h addr=%h valid=%b exp 0000/0004/1",
                         i, inst_pc, imem_addr, inst_valid);
            end
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (inst_pc !== 16'(2 * i) || inst_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp.release%0d pc=%h exp=%h", i, inst_pc, 16'(2 * i));
            end
            cycle();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run = 1'b1;
        cycle();
        cycle();
        cycle();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0011;
        cycle();
        redirect_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b0 || fetch_count !== 16'd1 || imem_addr !== 16'h0010) begin
            n_err++;
            $display("FAIL redir.flush valid=%b count=%0d addr=%h exp 0/1/0010",
                     inst_valid, fetch_count, imem_addr);
        end
        cycle();
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0010 || inst_data !== rom(16'h0010)) begin
            n_err++;
            $display("FAIL redir.target valid=%b pc=%h exp 1/0010", inst_valid, inst_pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1;
        cycle();
        cycle();
        cycle();
        run = 1'b0;
        halt_req = 1'b1;
        inst_ready = 1'b1;
        cycle();
        halt_req = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h2 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt.drain valid=%b pc=%h halted=%b exp 1/0002/0",
                     inst_valid, inst_pc, halted);
        end
        cycle();
        n_vec++;
        if (halted !== 1'b1 || fetch_count !== 16'd2 || imem_addr !== 16'h4) begin
            n_err++;
            $display("FAIL halt.done halted=%b count=%0d addr=%h exp 1/2/0004",
                     halted, fetch_count, imem_addr);
        end
        run = 1'b1;
        cycle();
        cycle();
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h4 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt.resume valid=%b pc=%h halted=%b exp 1/0004/0",
                     inst_valid, inst_pc, halted);
        end
    endtask

    task automatic test_halt_idle();
        do_reset();
        run = 1'b1;
        halt_req = 1'b1;
        cycle();
        run = 1'b0;
        halt_req = 1'b0;
        n_vec++;
        if (halted !== 1'b1 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL hidle.halted got=%b exp=1", halted);
        end
        cycle();
        n_vec++;
        if (halted !== 1'b1 || imem_addr !== 16'h0) begin
            n_err++;
            $display("FAIL hidle.stay halted=%b addr=%h exp 1/0000", halted, imem_addr);
        end
    endtask

    task automatic test_bound();
        logic [15:0] exp_pc;
        logic [15:0] last_pc;
        bit          saw_1e;
        do_reset();
        run = 1'b1;
        inst_ready = 1'b1;
        exp_pc = 16'h0;
        last_pc = 16'hFFFF;
        saw_1e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (inst_valid) begin
                n_vec++;
                if (inst_pc !== exp_pc) begin
                    n_err++; $display("FAIL bound.seq pc=%h exp=%h", inst_pc, exp_pc);
                end
                last_pc = inst_pc;
                if (inst_pc == 16'h001E) saw_1e = 1'b1;
                exp_pc = exp_pc + 16'd2;
            end
        end
        n_vec++;
`ifdef IFETCH_BOUND_EN
        if (last_pc !== 16'h001C || halted !== 1'b1) begin
            n_err++;
            $display("FAIL bound.stop last=%h halted=%b exp 001C/1", last_pc, halted);
        end
`else
        if (saw_1e !== 1'b1 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL bound.none saw1e=%b halted=%b exp 1/0", saw_1e, halted);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (inst_valid !== 1'b0 || imem_addr !== 16'h0 || fetch_count !== 16'h0
            || inst_pc !== 16'h0 || inst_data !== 16'h0 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL areset valid=%b addr=%h count=%h pc=%h data=%h halted=%b",
                     inst_valid, imem_addr, fetch_count, inst_pc, inst_data, halted);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic e_halt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            run = ($urandom_range(0, 9) < 7);
            halt_req = ($urandom_range(0, 24) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
            inst_ready = ($urandom_range(0, 9) < 6);
            cycle();
            e_halt = (m_st == 2) && (mq_pc.size() == 0);
            n_vec++;
            if (inst_valid !== (mq_pc.size() > 0) || imem_addr !== m_pc
                || fetch_count !== m_cnt || halted !== e_halt) begin
                n_err++;
                $display("FAIL rand%0d valid=%b addr=%h cnt=%h halted=%b exp %b/%h/%h/%b",
                         i, inst_valid, imem_addr, fetch_count, halted,
                         mq_pc.size() > 0, m_pc, m_cnt, e_halt);
            end
            if (mq_pc.size() > 0) begin
                n_vec++;
                if (inst_pc !== mq_pc[0] || inst_data !== mq_in[0]) begin
                    n_err++;
                    $display("FAIL rand%0d.head pc=%h data=%h exp %h/%h",
                             i, inst_pc, inst_data, mq_pc[0], mq_in[0]);
                end
            end
        end
    endtask

    initial begin
`ifdef IFETCH_BOUND_EN
        m_bound = 1'b1;
`else
        m_bound = 1'b0;
`endif
        model_reset();
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_halt();
        test_halt_idle();
        test_bound();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
